// File: rtl/vga_pkg.sv
// Shared timing defaults, colour types and the 16-entry palette for the VGA scanout block.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int READ_LATENCY = 3;
    localparam int ADDR_W       = 19;
    localparam int H_CNT_W      = 11;
    localparam int V_CNT_W      = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Timing flags carried down the alignment pipe alongside the pixel data.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vga_flags_t;

    localparam rgb444_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_timing.sv
// Raster counters and the combinational active/sync/frame flags for the current (h_cnt, v_cnt).
// With VGA_TEST_PATTERN_EN defined it also exports the colour-bar index h_cnt[9:6].
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef VGA_TEST_PATTERN_EN
    output logic [3:0] o_bar_idx,
`endif
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start,
    output logic       o_frame_end
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST  = H_CNT_W'(H_TOT - 1);
    localparam logic [H_CNT_W-1:0] H_AEND  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_BEG  = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] V_LAST  = V_CNT_W'(V_TOT - 1);
    localparam logic [V_CNT_W-1:0] V_AEND  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_BEG  = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] r_h_cnt;
    logic [V_CNT_W-1:0] r_v_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_comb begin
        o_active      = (r_h_cnt < H_AEND) && (r_v_cnt < V_AEND);
        o_hsync       = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
        o_vsync       = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
        o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
        o_frame_end   = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    end

`ifdef VGA_TEST_PATTERN_EN
    assign o_bar_idx = r_h_cnt[9:6];
`endif

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, framebuffer address walk, palette lookup and output alignment.
// Optional feature macro VGA_TEST_PATTERN_EN adds the test_pattern input (colour bars from h_cnt).
module vga_scanout #(
    parameter int   H_ACTIVE     = vga_pkg::H_ACTIVE,
    parameter int   H_FP         = vga_pkg::H_FP,
    parameter int   H_SYNC       = vga_pkg::H_SYNC,
    parameter int   H_BP         = vga_pkg::H_BP,
    parameter int   V_ACTIVE     = vga_pkg::V_ACTIVE,
    parameter int   V_FP         = vga_pkg::V_FP,
    parameter int   V_SYNC       = vga_pkg::V_SYNC,
    parameter int   V_BP         = vga_pkg::V_BP,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   READ_LATENCY = vga_pkg::READ_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [18:0] addr_vga,
    input  logic [3:0]  data_vga,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);
    import vga_pkg::*;

    localparam int PIPE = READ_LATENCY + 1;

    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_frame_start;
    logic       w_frame_end;
    logic [3:0] w_idx;

    logic [ADDR_W-1:0] r_addr;
    vga_flags_t        r_flag_a;
    vga_flags_t        r_pipe [PIPE];
    rgb444_t           r_rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic [3:0] w_bar_idx;
    logic [3:0] r_tp_idx [PIPE];
    logic       r_tp_sel [PIPE];
`endif

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .i_clk         (clock),
        .i_rst         (reset),
`ifdef VGA_TEST_PATTERN_EN
        .o_bar_idx     (w_bar_idx),
`endif
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign w_idx = r_tp_sel[PIPE-1] ? r_tp_idx[PIPE-1] : data_vga;

    // Bar index is captured at the address stage and travels with the read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                r_tp_idx[i] <= '0;
                r_tp_sel[i] <= 1'b0;
            end
        end else begin
            r_tp_idx[0] <= w_bar_idx;
            r_tp_sel[0] <= test_pattern;
            for (int i = 1; i < PIPE; i++) begin
                r_tp_idx[i] <= r_tp_idx[i-1];
                r_tp_sel[i] <= r_tp_sel[i-1];
            end
        end
    end
`else
    assign w_idx = data_vga;
`endif

    // Address stage runs one clock behind the counters; flags are registered with it so that
    // the PIPE-deep shift lines them up with the palette register output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_flag_a <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_pipe[i] <= '0;
            end
            r_rgb    <= '0;
        end else begin
            if (w_frame_end) begin
                r_addr <= '0;
            end else if (w_active && !w_frame_start) begin
                r_addr <= r_addr + 1'b1;
            end
            r_flag_a <= '{hs: w_hsync, vs: w_vsync, de: w_active, fs: w_frame_start};
            r_pipe[0] <= r_flag_a;
            for (int i = 1; i < PIPE; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_rgb <= r_pipe[PIPE-2].de ? PALETTE[w_idx] : rgb444_t'('0);
        end
    end

    assign addr_vga    = r_addr;
    assign vga_hsync   = r_pipe[PIPE-1].hs ? SYNC_POL : ~SYNC_POL;
    assign vga_vsync   = r_pipe[PIPE-1].vs ? SYNC_POL : ~SYNC_POL;
    assign vga_de      = r_pipe[PIPE-1].de;
    assign frame_start = r_pipe[PIPE-1].fs;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;

endmodule
